// File: rtl/div_ctrl_pkg.sv
// Shared types for the DIV/DIVU sequencer: FSM state encoding and counter width.
package div_ctrl_pkg;
    localparam int DIV_CNT_W = 6;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_BUSY = 2'b01,
        DIV_DONE = 2'b10
    } div_state_e;
endpackage

// File: rtl/div_ctrl_if.sv
// EX-stage <-> divider signal bundle; the master is the EX glue, the slave is div_ctrl.
interface div_ctrl_if #(parameter int WIDTH = 32) ();
    // Handshake: start_i is a level request taken only while the divider is idle;
    // done_o is "result valid" and hold_i acts as !ready, so a result stays put while hold_i=1;
    // flush_i aborts unconditionally and overrides both.
    logic             start_i;
    logic             signed_i;
    logic [WIDTH-1:0] opa_i;
    logic [WIDTH-1:0] opb_i;
    logic             flush_i;
    logic             hold_i;
    logic             stall_o;
    logic             done_o;
    logic [WIDTH-1:0] lo_o;
    logic [WIDTH-1:0] hi_o;
    logic [1:0]       state_dbg;

    modport master (
        output start_i, signed_i, opa_i, opb_i, flush_i, hold_i,
        input  stall_o, done_o, lo_o, hi_o, state_dbg
    );

    modport slave (
        input  start_i, signed_i, opa_i, opb_i, flush_i, hold_i,
        output stall_o, done_o, lo_o, hi_o, state_dbg
    );
endinterface

// File: rtl/div_ctrl_step.sv
// One radix-2 restoring division step: shift {rem,quo} left, trial-subtract the divisor.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH-1:0] rem_next_o,
    output logic [WIDTH-1:0] quo_next_o
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        shifted = {rem_i, quo_i[WIDTH-1]};
        diff    = shifted - {1'b0, div_i};
        // rem < div on entry, so a non-negative difference always fits back in WIDTH bits.
        if (!diff[WIDTH]) begin
            rem_next_o = diff[WIDTH-1:0];
            quo_next_o = {quo_i[WIDTH-2:0], 1'b1};
        end else begin
            rem_next_o = shifted[WIDTH-1:0];
            quo_next_o = {quo_i[WIDTH-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle DIV/DIVU sequencer for the EX stage: stalls the pipe while iterating,
// then presents quotient on LO and remainder on HI.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       resetn,
    div_ctrl_if.slave  bus
);
    localparam logic [DIV_CNT_W-1:0] CNT_LAST = DIV_CNT_W'(WIDTH - 1);

    div_state_e           state_q, state_d;
    logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [WIDTH-1:0]     div_q, div_d;
    logic                 sgn_q, sgn_d;
    logic                 sa_q, sa_d;
    logic                 sx_q, sx_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic                 stall;
    logic [WIDTH-1:0]     rem_next, quo_next;
    logic [WIDTH-1:0]     opa_abs, opb_abs;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i      (rem_q),
        .quo_i      (quo_q),
        .div_i      (div_q),
        .rem_next_o (rem_next),
        .quo_next_o (quo_next)
    );

    always_comb begin
        opa_abs = (bus.signed_i && bus.opa_i[WIDTH-1]) ? -bus.opa_i : bus.opa_i;
        opb_abs = (bus.signed_i && bus.opb_i[WIDTH-1]) ? -bus.opb_i : bus.opb_i;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        div_d   = div_q;
        sgn_d   = sgn_q;
        sa_d    = sa_q;
        sx_d    = sx_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        stall   = 1'b0;
        if (bus.flush_i) begin
            state_d = DIV_IDLE;
        end else begin
            unique case (state_q)
                DIV_IDLE: begin
                    if (bus.start_i) begin
                        stall = 1'b1;
                        cnt_d = '0;
                        rem_d = '0;
                        quo_d = opa_abs;
                        div_d = opb_abs;
                        sgn_d = bus.signed_i;
                        sa_d  = bus.opa_i[WIDTH-1];
                        sx_d  = bus.opa_i[WIDTH-1] ^ bus.opb_i[WIDTH-1];
                        // Divide by zero skips iteration; HI returns the raw dividend.
                        if (bus.opb_i == '0) begin
                            lo_d    = '1;
                            hi_d    = bus.opa_i;
                            state_d = DIV_DONE;
                        end else begin
                            state_d = DIV_BUSY;
                        end
                    end
                end
                DIV_BUSY: begin
                    stall = 1'b1;
                    rem_d = rem_next;
                    quo_d = quo_next;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = DIV_DONE;
                        lo_d    = (sgn_q && sx_q) ? -quo_next : quo_next;
                        hi_d    = (sgn_q && sa_q) ? -rem_next : rem_next;
                    end
                end
                DIV_DONE: begin
                    if (!bus.hold_i) state_d = DIV_IDLE;
                end
                default: state_d = DIV_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            div_q   <= '0;
            sgn_q   <= 1'b0;
            sa_q    <= 1'b0;
            sx_q    <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            div_q   <= div_d;
            sgn_q   <= sgn_d;
            sa_q    <= sa_d;
            sx_q    <= sx_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
        end
    end

    assign bus.stall_o   = stall;
    assign bus.done_o    = (state_q == DIV_DONE);
    assign bus.lo_o      = lo_q;
    assign bus.hi_o      = hi_q;
    assign bus.state_dbg = state_q;
endmodule
